// File: rtl/cd_rx_frag_buf.sv
// RX frame buffer for the cdbus receive path: frames are stored in a circular
// pool of fixed-size blocks and handed to the host in FIFO order.

module cd_sdpram #(
  parameter int A_WIDTH = 11,
  parameter int D_WIDTH = 8
) (
  input  logic               clk,
  input  logic               wr_en,
  input  logic [A_WIDTH-1:0] wr_addr,
  input  logic [D_WIDTH-1:0] wr_data,
  input  logic               rd_en,
  input  logic [A_WIDTH-1:0] rd_addr,
  output logic [D_WIDTH-1:0] rd_data
);
  logic [D_WIDTH-1:0] mem [2**A_WIDTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end
endmodule

module cd_rx_frag_buf #(
  parameter int I_WIDTH = 6,
  parameter int B_WIDTH = 11,
  parameter int L_WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [7:0]         wr_byte,
  input  logic [L_WIDTH-1:0] wr_addr,
  input  logic               wr_en,
  input  logic               wr_commit,
  input  logic               wr_err,
  input  logic               wr_abort,
  output logic               commit_fail,
  input  logic [L_WIDTH-1:0] rd_addr,
  input  logic               rd_en,
  output logic [7:0]         rd_byte,
  input  logic               rd_done,
  input  logic               clear,
  output logic               unread,
  output logic [L_WIDTH:0]   rd_len,
  output logic               rd_err,
  output logic [I_WIDTH:0]   frame_cnt,
  output logic [I_WIDTH:0]   free_blocks,
  output logic [7:0]         drop_cnt
);
  localparam int S_WIDTH = B_WIDTH - I_WIDTH;
  localparam int F_WIDTH = L_WIDTH - S_WIDTH;
  localparam int N_BLK   = 2**I_WIDTH;
  localparam int N_FRAG  = 2**F_WIDTH;

  typedef struct packed {
    logic               err;
    logic [F_WIDTH-1:0] frag_max;
    logic [L_WIDTH:0]   len;
  } idx_entry_t;

  idx_entry_t         idx_table [N_BLK];
  idx_entry_t         rd_entry;
  logic [N_BLK-1:0]   dirty;
  logic [N_BLK-1:0]   set_mask;
  logic [N_BLK-1:0]   clr_mask;
  logic [I_WIDTH-1:0] wr_sel;
  logic [I_WIDTH-1:0] rd_sel;

  // state of the frame currently being received
  logic               ovf;
  logic [F_WIDTH-1:0] frag_max;
  logic [L_WIDTH:0]   len;
  logic               commit_d;
  logic               err_d;

  logic               ram_we;
  logic [B_WIDTH-1:0] ram_waddr;
  logic [7:0]         ram_wdata;
  logic [B_WIDTH-1:0] ram_raddr;

  logic [F_WIDTH-1:0] wr_frag;
  logic [I_WIDTH-1:0] wr_blk;
  logic [I_WIDTH-1:0] rd_blk;
  logic [L_WIDTH:0]   wr_len;
  logic               wr_ok;
  logic               commit_go;
  logic               commit_q;
  logic               commit_drop;
  logic               done_go;
  logic               unread_nxt;
  logic [I_WIDTH:0]   wr_span;
  logic [I_WIDTH:0]   rd_span;
  logic [I_WIDTH:0]   add_span;
  logic [I_WIDTH:0]   rel_span;

  assign wr_frag  = wr_addr[L_WIDTH-1:S_WIDTH];
  assign wr_blk   = wr_sel + I_WIDTH'(wr_frag);
  assign wr_len   = (L_WIDTH+1)'(wr_addr) + (L_WIDTH+1)'(1);
  assign rd_blk   = rd_sel + I_WIDTH'(rd_addr[L_WIDTH-1:S_WIDTH]);
  assign ram_raddr = {rd_blk, rd_addr[S_WIDTH-1:0]};
  assign rd_entry = idx_table[rd_sel];

  // Bytes arriving while a commit is being applied would land in blocks that
  // are just becoming owned by the queued frame, so they are dropped.
  assign wr_ok = wr_en & ~clear & ~commit_d & ~ovf & ~dirty[wr_blk];

  assign commit_go   = commit_d & ~wr_abort & ~clear;
  assign commit_q    = commit_go & ~ovf & (len != '0);
  assign commit_drop = commit_go & ovf;
  assign done_go     = rd_done & unread & ~clear;
  assign unread_nxt  = dirty[rd_sel] & ~done_go;

  assign wr_span  = (I_WIDTH+1)'(frag_max) + (I_WIDTH+1)'(1);
  assign rd_span  = (I_WIDTH+1)'(rd_entry.frag_max) + (I_WIDTH+1)'(1);
  assign add_span = commit_q ? wr_span : '0;
  assign rel_span = done_go ? rd_span : '0;

  // Ranges set by a commit and cleared by a release never overlap.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    for (int k = 0; k < N_FRAG; k++) begin
      if (commit_q && (F_WIDTH'(k) <= frag_max))
        set_mask[wr_sel + I_WIDTH'(k)] = 1'b1;
      if (done_go && (F_WIDTH'(k) <= rd_entry.frag_max))
        clr_mask[rd_sel + I_WIDTH'(k)] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dirty       <= '0;
      wr_sel      <= '0;
      rd_sel      <= '0;
      frame_cnt   <= '0;
      free_blocks <= (I_WIDTH+1)'(N_BLK);
      commit_d    <= 1'b0;
      err_d       <= 1'b0;
      commit_fail <= 1'b0;
      drop_cnt    <= '0;
      unread      <= 1'b0;
      rd_len      <= '0;
      rd_err      <= 1'b0;
      ram_we      <= 1'b0;
      ram_waddr   <= '0;
      ram_wdata   <= '0;
    end else if (clear) begin
      dirty       <= '0;
      wr_sel      <= '0;
      rd_sel      <= '0;
      frame_cnt   <= '0;
      free_blocks <= (I_WIDTH+1)'(N_BLK);
      commit_d    <= 1'b0;
      err_d       <= 1'b0;
      commit_fail <= 1'b0;
      drop_cnt    <= '0;
      unread      <= 1'b0;
      rd_len      <= '0;
      rd_err      <= 1'b0;
      ram_we      <= 1'b0;
      ram_waddr   <= '0;
      ram_wdata   <= '0;
    end else begin
      dirty       <= (dirty | set_mask) & ~clr_mask;
      frame_cnt   <= frame_cnt + (I_WIDTH+1)'(commit_q) - (I_WIDTH+1)'(done_go);
      free_blocks <= free_blocks - add_span + rel_span;
      if (commit_q) wr_sel <= wr_sel + wr_span[I_WIDTH-1:0];
      if (done_go)  rd_sel <= rd_sel + rd_span[I_WIDTH-1:0];
      commit_d    <= wr_commit & ~wr_abort;
      err_d       <= wr_err;
      commit_fail <= commit_drop;
      if (commit_drop && drop_cnt != 8'hff) drop_cnt <= drop_cnt + 8'd1;
      unread      <= unread_nxt;
      rd_len      <= unread_nxt ? rd_entry.len : '0;
      rd_err      <= unread_nxt & rd_entry.err;
      ram_we      <= wr_ok;
      ram_waddr   <= {wr_blk, wr_addr[S_WIDTH-1:0]};
      ram_wdata   <= wr_byte;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf      <= 1'b0;
      frag_max <= '0;
      len      <= '0;
    end else if (clear || wr_abort || commit_d) begin
      ovf      <= 1'b0;
      frag_max <= '0;
      len      <= '0;
    end else if (wr_en) begin
      if (!wr_ok) begin
        ovf <= 1'b1;
      end else begin
        if (wr_frag > frag_max) frag_max <= wr_frag;
        if (wr_len > len) len <= wr_len;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (commit_q) idx_table[wr_sel] <= {err_d, frag_max, len};
  end

  cd_sdpram #(
    .A_WIDTH(B_WIDTH),
    .D_WIDTH(8)
  ) u_ram (
    .clk     (clk),
    .wr_en   (ram_we),
    .wr_addr (ram_waddr),
    .wr_data (ram_wdata),
    .rd_en   (rd_en),
    .rd_addr (ram_raddr),
    .rd_data (rd_byte)
  );
endmodule

// File: tb/tb_cd_rx_frag_buf.sv
// Self-checking bench for cd_rx_frag_buf: fixed vectors, corner sequences and
// randomized frames against a frame-level queue model.

module tb_cd_rx_frag_buf;
  localparam int NBLK = 64;
  localparam int BLK_BYTES = 32;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] wr_byte = '0;
  logic [7:0] wr_addr = '0;
  logic       wr_en = 1'b0;
  logic       wr_commit = 1'b0;
  logic       wr_err = 1'b0;
  logic       wr_abort = 1'b0;
  logic       commit_fail;
  logic [7:0] rd_addr = '0;
  logic       rd_en = 1'b0;
  logic [7:0] rd_byte;
  logic       rd_done = 1'b0;
  logic       clear = 1'b0;
  logic       unread;
  logic [8:0] rd_len;
  logic       rd_err;
  logic [6:0] frame_cnt;
  logic [6:0] free_blocks;
  logic [7:0] drop_cnt;

  cd_rx_frag_buf dut (
    .clk(clk), .reset_n(reset_n), .wr_byte(wr_byte), .wr_addr(wr_addr),
    .wr_en(wr_en), .wr_commit(wr_commit), .wr_err(wr_err), .wr_abort(wr_abort),
    .commit_fail(commit_fail), .rd_addr(rd_addr), .rd_en(rd_en),
    .rd_byte(rd_byte), .rd_done(rd_done), .clear(clear), .unread(unread),
    .rd_len(rd_len), .rd_err(rd_err), .frame_cnt(frame_cnt),
    .free_blocks(free_blocks), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int           len;
    bit           err;
    byte unsigned data[256];
  } frame_t;

  typedef struct {
    int len;
    bit err;
    int exp_free;
  } vec_t;

  frame_t       mq[$];
  int           m_wsel, m_rsel, m_used, m_drops;
  byte unsigned wbuf[256];
  int           checks, errors;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic int nblk(input int len);
    return (len + BLK_BYTES - 1) / BLK_BYTES;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_wsel = 0; m_rsel = 0; m_used = 0; m_drops = 0;
  endtask

  // Occupied blocks are the circular span rd..rd+used-1.
  function automatic bit pred_ovf(input int len);
    for (int k = 0; k < nblk(len); k++)
      if (((m_wsel + k - m_rsel + 2*NBLK) % NBLK) < m_used) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check_counts();
    chk("frame_cnt", frame_cnt, mq.size());
    chk("free_blocks", free_blocks, NBLK - m_used);
    chk("drop_cnt", drop_cnt, (m_drops > 255) ? 255 : m_drops);
    chk("unread", unread, (mq.size() > 0) ? 1 : 0);
    if (mq.size() > 0) begin
      chk("rd_len", rd_len, mq[0].len);
      chk("rd_err", rd_err, mq[0].err);
    end
  endtask

  // mode 0: commit, 1: abort together with commit, 2: abort after the bytes
  task automatic send_frame(input int len, input bit err, input int mode, output int cf);
    for (int i = 0; i < len; i++) begin
      wr_en = 1'b1; wr_addr = 8'(i); wr_byte = wbuf[i];
      if (i == len - 1 && mode != 2) begin
        wr_commit = 1'b1; wr_err = err;
        if (mode == 1) wr_abort = 1'b1;
      end
      step();
    end
    wr_en = 1'b0; wr_commit = 1'b0; wr_abort = 1'b0; wr_err = 1'b0;
    if (mode == 2) begin
      wr_abort = 1'b1; step(); wr_abort = 1'b0;
    end
    cf = 0;
    repeat (3) begin
      step();
      if (commit_fail) cf++;
    end
  endtask

  task automatic do_frame(input int len, input bit err, input int mode);
    int cf;
    bit ov;
    frame_t f;
    for (int i = 0; i < 256; i++) wbuf[i] = 8'($urandom);
    ov = (mode == 0) && pred_ovf(len);
    send_frame(len, err, mode, cf);
    if (mode == 0) begin
      if (ov) m_drops++;
      else begin
        f.len = len; f.err = err; f.data = wbuf;
        mq.push_back(f);
        m_wsel = (m_wsel + nblk(len)) % NBLK;
        m_used += nblk(len);
      end
    end
    chk("commit_fail_pulses", cf, (mode == 0 && ov) ? 1 : 0);
    check_counts();
  endtask

  task automatic rd_check(input int off, input int exp);
    rd_en = 1'b1; rd_addr = 8'(off);
    step();
    rd_en = 1'b0;
    chk("rd_byte", rd_byte, exp);
  endtask

  // nread < 0 reads the whole frame back-to-back, otherwise random offsets
  task automatic do_done(input int nread);
    frame_t f;
    int w, o;
    f = mq[0];
    if (nread < 0) begin
      for (int i = 0; i < f.len; i++) rd_check(i, f.data[i]);
    end else begin
      for (int i = 0; i < nread; i++) begin
        o = $urandom_range(0, f.len - 1);
        rd_check(o, f.data[o]);
      end
    end
    w = 0;
    while (!unread && w < 8) begin step(); w++; end
    chk("unread_before_done", unread, 1);
    rd_done = 1'b1; step(); rd_done = 1'b0;
    chk("unread_forced_low", unread, 0);
    step();
    m_rsel = (m_rsel + nblk(f.len)) % NBLK;
    m_used -= nblk(f.len);
    void'(mq.pop_front());
    check_counts();
  endtask

  task automatic clear_all();
    clear = 1'b1; step(); clear = 1'b0; step();
    model_reset();
  endtask

  initial begin
    vec_t vecs[9];
    int cf, total;
    vecs[0] = '{1, 1'b0, 63};
    vecs[1] = '{32, 1'b1, 63};
    vecs[2] = '{33, 1'b0, 62};
    vecs[3] = '{40, 1'b1, 62};
    vecs[4] = '{64, 1'b0, 62};
    vecs[5] = '{65, 1'b1, 61};
    vecs[6] = '{100, 1'b0, 60};
    vecs[7] = '{255, 1'b1, 56};
    vecs[8] = '{256, 1'b0, 56};
    checks = 0; errors = 0;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    chk("rst_frame_cnt", frame_cnt, 0);
    chk("rst_free", free_blocks, 64);
    chk("rst_unread", unread, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_commit_fail", commit_fail, 0);
    chk("rst_rd_len", rd_len, 0);
    chk("rst_rd_err", rd_err, 0);
    reset_n = 1'b1;
    step();

    foreach (vecs[i]) begin
      do_frame(vecs[i].len, vecs[i].err, 0);
      chk("vec_frame_cnt", frame_cnt, 1);
      chk("vec_free", free_blocks, vecs[i].exp_free);
      chk("vec_rd_len", rd_len, vecs[i].len);
      chk("vec_rd_err", rd_err, vecs[i].err);
      do_done(-1);
      chk("vec_free_after", free_blocks, 64);
    end

    // three frames of 1, 33, 256 bytes released in order
    clear_all();
    do_frame(1, 1'b0, 0);
    do_frame(33, 1'b1, 0);
    do_frame(256, 1'b0, 0);
    chk("seq_free", free_blocks, 53);
    do_done(-1);
    chk("seq_free1", free_blocks, 54);
    chk("seq_len1", rd_len, 33);
    do_done(-1);
    chk("seq_free2", free_blocks, 56);
    chk("seq_len2", rd_len, 256);
    do_done(-1);
    chk("seq_free3", free_blocks, 64);
    chk("seq_unread3", unread, 0);

    // abort variants, then a 5-byte frame
    clear_all();
    do_frame(10, 1'b0, 2);
    do_frame(10, 1'b1, 1);
    wr_en = 1'b1; wr_addr = 8'd0; wr_byte = 8'h5a; wr_commit = 1'b1; step();
    wr_en = 1'b0; wr_commit = 1'b0; wr_abort = 1'b1; step(); wr_abort = 1'b0;
    total = 0;
    repeat (3) begin step(); if (commit_fail) total++; end
    chk("abort_pending_pulses", total, 0);
    chk("abort_pending_cnt", frame_cnt, 0);
    do_frame(5, 1'b0, 0);
    chk("abort_frame_cnt", frame_cnt, 1);
    chk("abort_rd_len", rd_len, 5);
    chk("abort_free", free_blocks, 63);
    do_done(-1);

    // commit effect and rd_done on the same edge
    clear_all();
    do_frame(40, 1'b0, 0);
    do_frame(70, 1'b1, 0);
    for (int i = 0; i < 256; i++) wbuf[i] = 8'($urandom);
    for (int i = 0; i < 20; i++) begin
      wr_en = 1'b1; wr_addr = 8'(i); wr_byte = wbuf[i];
      if (i == 19) wr_commit = 1'b1;
      step();
    end
    wr_en = 1'b0; wr_commit = 1'b0;
    rd_done = 1'b1; step(); rd_done = 1'b0;
    chk("simul_frame_cnt", frame_cnt, 2);
    chk("simul_free", free_blocks, 60);
    begin
      frame_t f;
      f.len = 20; f.err = 1'b0; f.data = wbuf;
      m_rsel = (m_rsel + 2) % NBLK; m_used -= 2;
      void'(mq.pop_front());
      mq.push_back(f);
      m_wsel = (m_wsel + 1) % NBLK; m_used += 1;
    end
    step();
    check_counts();
    while (mq.size() > 0) do_done(-1);

    // frame straddling the end of the pool
    clear_all();
    for (int i = 0; i < 7; i++) begin
      do_frame(256, 1'b0, 0);
      do_done(4);
    end
    do_frame(192, 1'b0, 0);
    do_done(4);
    do_frame(100, 1'b1, 0);
    chk("wrap_free", free_blocks, 60);
    chk("wrap_rd_len", rd_len, 100);
    do_done(-1);
    chk("wrap_free_after", free_blocks, 64);

    // full pool, overflow drops and drop counter saturation
    clear_all();
    for (int i = 0; i < 8; i++) do_frame(256, 1'b0, 0);
    chk("full_free", free_blocks, 0);
    chk("full_frame_cnt", frame_cnt, 8);
    do_frame(256, 1'b1, 0);
    chk("full_drop1", drop_cnt, 1);
    chk("full_cnt_after_drop", frame_cnt, 8);
    total = 0;
    for (int i = 0; i < 299; i++) begin
      wbuf[0] = 8'($urandom);
      send_frame(1, 1'b0, 0, cf);
      total += cf;
      m_drops++;
    end
    chk("drop_pulses", total, 299);
    chk("drop_saturated", drop_cnt, 255);
    check_counts();

    // clear on the same cycle as a commit
    wr_en = 1'b1; wr_addr = 8'd0; wr_commit = 1'b1; clear = 1'b1;
    step();
    wr_en = 1'b0; wr_commit = 1'b0; clear = 1'b0;
    total = 0;
    repeat (3) begin step(); if (commit_fail) total++; end
    model_reset();
    chk("clear_pulses", total, 0);
    check_counts();

    // clear while the commit is pending
    for (int i = 0; i < 10; i++) begin
      wr_en = 1'b1; wr_addr = 8'(i); wr_byte = 8'(i);
      if (i == 9) wr_commit = 1'b1;
      step();
    end
    wr_en = 1'b0; wr_commit = 1'b0; clear = 1'b1; step(); clear = 1'b0;
    step(); step();
    check_counts();

    // randomized frames against the queue model
    clear_all();
    for (int n = 0; n < 150; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 45 || (r >= 55 && mq.size() == 0))
        do_frame($urandom_range(1, 256), 1'($urandom_range(0, 1)), 0);
      else if (r < 55)
        do_frame($urandom_range(1, 256), 1'($urandom_range(0, 1)), $urandom_range(1, 2));
      else
        do_done(8);
    end
    while (mq.size() > 0) do_done(4);
    chk("rand_free_end", free_blocks, 64);

    // asynchronous reset mid-frame
    do_frame(50, 1'b1, 0);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("async_free", free_blocks, 64);
    chk("async_frame_cnt", frame_cnt, 0);
    chk("async_unread", unread, 0);
    step();
    reset_n = 1'b1;
    model_reset();
    step();
    check_counts();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cd_rx_frag_buf.md
Name: cd_rx_frag_buf

Overview:
- Next-generation RX frame buffer for the cdbus receive path.
- Frames are stored in a circular pool of fixed-size blocks and queued for the host in FIFO order.
- Compared with the previous generation it adds:
  - parametrised maximum frame length;
  - a stored true length and error flag per frame;
  - whole-frame block reservation;
  - explicit abort;
  - frame and free-block occupancy outputs;
  - a saturating dropped-frame counter.

Parameters:
- I_WIDTH, 6, index bit width; pool holds 2^I_WIDTH blocks.
- B_WIDTH, 11, buffer byte-address width; 2^B_WIDTH bytes total.
- L_WIDTH, 8, frame byte-offset width; max frame 2^L_WIDTH bytes. Must satisfy L_WIDTH > B_WIDTH-I_WIDTH.
- Derived (localparam): S_WIDTH = B_WIDTH-I_WIDTH (block is 2^S_WIDTH bytes); F_WIDTH = L_WIDTH-S_WIDTH (fragment index width).

Ports:
- clk, input, 1, clock.
- reset_n, input, 1, asynchronous active-low reset.
- wr_byte, input, 8, write data.
- wr_addr, input, L_WIDTH, byte offset within the current frame.
- wr_en, input, 1, write strobe.
- wr_commit, input, 1, pulse: end of current frame, queue it.
- wr_err, input, 1, error flag stored with the frame; sampled with wr_commit.
- wr_abort, input, 1, pulse: discard the current frame silently.
- commit_fail, output, 1, one-cycle pulse: a commit was dropped due to overflow.
- rd_addr, input, L_WIDTH, byte offset within the head frame.
- rd_en, input, 1, read strobe.
- rd_byte, output, 8, read data; valid 1 cycle after rd_en.
- rd_done, input, 1, pulse: release the head frame.
- clear, input, 1, pulse: flush everything.
- unread, output, 1, head frame valid.
- rd_len, output, L_WIDTH+1, head frame length in bytes (1..2^L_WIDTH).
- rd_err, output, 1, head frame error flag.
- frame_cnt, output, I_WIDTH+1, number of queued frames.
- free_blocks, output, I_WIDTH+1, number of unreserved blocks.
- drop_cnt, output, 8, dropped frames; saturates at 255.

Behaviour:
- Reset values:
  - all pointers, dirty bits, counters, commit_fail, unread, rd_len, rd_err = 0;
  - drop_cnt = 0;
  - free_blocks = 2^I_WIDTH;
  - index table contents are don't-care.
- Storage:
  - Byte RAM is an inferred simple dual-port cd_sdpram, A_WIDTH=B_WIDTH, registered read.
  - Index table holds {err, frag_max[F_WIDTH], len[L_WIDTH+1]} per block index.
- Write path:
  - Target block = (wr_sel + wr_addr[L_WIDTH-1:S_WIDTH]) mod 2^I_WIDTH.
  - RAM address = {target block, wr_addr[S_WIDTH-1:0]}.
  - The RAM write is registered and occurs 1 cycle after wr_en.
  - If the target block is dirty, or an overflow is already flagged:
    - the byte is discarded;
    - the overflow flag is set for the rest of the frame.
  - Otherwise the byte is written, and the block tracks frag_max = max fragment index and len = max(wr_addr)+1.
- Commit:
  - wr_commit is registered (commit_d).
  - A byte with wr_en in the same cycle as wr_commit belongs to the committing frame.
  - The commit takes effect at the edge ending the cycle after wr_commit:
    - Overflow flagged: no queue entry; commit_fail pulses 1 cycle; drop_cnt += 1 (saturating).
    - len == 0: ignored; no pulse, no count.
    - Otherwise:
      - idx_table[wr_sel] <= {wr_err, frag_max, len};
      - dirty is set for blocks wr_sel..wr_sel+frag_max (mod 2^I_WIDTH);
      - wr_sel advances by frag_max+1;
      - frame_cnt += 1;
      - free_blocks -= frag_max+1.
  - The per-frame state (overflow, frag_max, len) is then cleared.
- wr_abort:
  - Clears per-frame state at the next edge; wr_sel is unchanged.
  - If wr_abort is asserted with wr_commit or with a pending commit_d, abort wins: the frame is discarded with no pulse and no count.
- Read path:
  - RAM address = {rd_sel + rd_addr[L_WIDTH-1:S_WIDTH], rd_addr[S_WIDTH-1:0]}.
  - rd_byte is valid the cycle after rd_en.
  - unread, rd_len and rd_err are registered from dirty[rd_sel] and idx_table[rd_sel], so they lag state by 1 cycle.
- rd_done:
  - If unread == 1:
    - clear the dirty range rd_sel..rd_sel+frag_max;
    - rd_sel advances by frag_max+1;
    - frame_cnt -= 1;
    - free_blocks += frag_max+1;
    - unread is forced to 0 for the following cycle.
  - If unread == 0: ignored.
- Simultaneous commit effect and rd_done: both apply. The set and clear ranges are disjoint by construction. Counters use the net change.
- Wrap-around: all block arithmetic is modulo 2^I_WIDTH. A frame may straddle the end of the pool.
- Full pool: every block dirty; every write overflows; the frame is dropped at commit.
- clear:
  - Highest priority: overrides write, commit, abort and rd_done in the same cycle.
  - Everything returns to reset values, including drop_cnt; a pending commit_d is discarded.
- Reset asserted mid-frame or mid-read: immediate asynchronous return to reset values.

Test Plan:
- Write 40 bytes (offsets 0..39), wr_err=1, commit -> after 2 cycles: frame_cnt=1, free_blocks=62, unread=1, rd_len=40, rd_err=1; read back offsets 0..39 match, 1-cycle latency.
- Queue 3 frames of 1, 33, 256 bytes; rd_done each in turn -> rd_sel advances 1, 2, 8; rd_len sequence 1, 33, 256; free_blocks returns to 64; unread=0 after the last.
- Fill the pool with 8 frames of 256 bytes, then write a 9th frame and commit -> commit_fail pulses once, drop_cnt=1, frame_cnt=8; repeat 300 times -> drop_cnt=255.
- With wr_sel=62, commit a 100-byte frame -> blocks 62, 63, 0, 1 dirty; data read back intact across the wrap; rd_done frees 4 blocks.
- Write 10 bytes then wr_abort, then commit a 5-byte frame -> only the 5-byte frame is queued at the same wr_sel; no commit_fail.
- Assert commit and rd_done in the same cycle with frame_cnt=2 -> frame_cnt stays 2. Assert clear together with a commit -> all counters 0, unread=0.
